// File: rtl/furv_pkg.sv
// furv_pkg -- shared definitions for the FURV data-memory block.
//   Address map constants (RAM base, CYCLE, TXDATA, STATUS), STATUS bit
//   positions, the decoded region type, and the address decoder used by
//   furv_dmem.
package furv_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'h8000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;

    // STATUS register layout; every bit not listed reads 0
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_CNT_LSB   = 2;
    localparam int ST_CNT_MSB   = 5;
    localparam int ST_OVF_BIT   = 6;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_CYCLE,
        RGN_TXDATA,
        RGN_STATUS,
        RGN_NONE
    } region_e;

    // Word-granular decode: addr[1:0] never takes part in the match.
    // ram_aw is log2 of the RAM depth in words.
    function automatic region_e decode(input logic [31:0] addr, input int ram_aw);
        if (((addr - RAM_BASE) >> (ram_aw + 2)) == 32'd0)
            return RGN_RAM;
        if (addr[31:2] == CYCLE_ADDR[31:2])
            return RGN_CYCLE;
        if (addr[31:2] == TXDATA_ADDR[31:2])
            return RGN_TXDATA;
        if (addr[31:2] == STATUS_ADDR[31:2])
            return RGN_STATUS;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/furv_txfifo.sv
// furv_txfifo -- byte FIFO feeding the TX stream.
//   Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH and a
//   separate occupancy count, plus a sticky overflow flag.
// Ports:
//   clk, rst_n        clock, async active-low reset (pointers/count/overflow)
//   push_i/push_data_i push request and byte
//   pop_i             downstream accepted the head (ignored when empty)
//   ovf_clr_i         clear the overflow flag (a same-edge overflow wins)
//   full_o, empty_o, count_o  occupancy from the registered count
//   head_o            byte at the head, valid while !empty_o
//   overflow_o        sticky: a push was dropped because the FIFO was full
// FIFO_DEPTH must be a power of two, at least 2.
module furv_txfifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [7:0]    head_o,
    output logic          overflow_o
);

    logic [7:0]    buf_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic do_pop, do_push, drop;

    assign full_o     = (count_q == CW'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_o     = buf_q[rd_ptr_q];
    assign overflow_o = ovf_q;

    // A pop frees a slot at the same edge, so a push into a full FIFO still
    // lands when the head leaves simultaneously.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop    = push_i && full_o && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // set beats clear when both happen at the same edge
            if (drop)           ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

    // Storage is not reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/furv_dmem.sv
// furv_dmem -- data-side memory block for a single-cycle core.
//   Word RAM, free-running CYCLE counter, TX byte FIFO (TXDATA/STATUS) and a
//   bus-error pulse for unmapped accesses, all behind one shared data bus.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   data  (inout 32)   driven here only on reads, high-Z otherwise
//   addr  (32)         byte address, low two bits ignored
//   mem, mem_read      access strobe and direction (1 = read)
//   tx_data/tx_valid   FIFO head and non-empty flag
//   tx_ready           downstream takes tx_data at this edge
//   bus_err            one-cycle pulse after an unmapped access
module furv_dmem
    import furv_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [31:0] data,
    input  logic [31:0] addr,
    input  logic        mem,
    input  logic        mem_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    region_e       region;
    logic          rd_en, wr_en;
    logic [31:0]   rdata, status_w;
    logic [31:0]   cycle_q, cycle_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   ram_q [RAM_WORDS];
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;

    assign region = decode(addr, AW);
    assign rd_en  = mem && mem_read;
    // A write still pending when reset asserts is lost rather than landing on
    // a clock edge during reset.
    assign wr_en  = rst_n && mem && !mem_read;

    // ---------------- RAM: no reset, contents survive rst_n ----------------
    always_ff @(posedge clk) begin
        if (wr_en && region == RGN_RAM) ram_q[addr[AW+1:2]] <= data;
    end

    // ---------------- CYCLE counter and bus error pulse ----------------
    assign cycle_d   = cycle_q + 32'd1;
    assign bus_err_d = mem && (region == RGN_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;

    // ---------------- TX FIFO ----------------
    furv_txfifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_txfifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (wr_en && region == RGN_TXDATA),
        .push_data_i(data[7:0]),
        .pop_i      (tx_ready),
        // the read returns the pre-clear value; the flag drops at the edge
        .ovf_clr_i  (rd_en && region == RGN_STATUS),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .head_o     (tx_data),
        .overflow_o (fifo_ovf)
    );

    assign tx_valid = !fifo_empty;

    // ---------------- read mux and bus driver ----------------
    always_comb begin
        status_w                        = '0;
        status_w[ST_FULL_BIT]           = fifo_full;
        status_w[ST_EMPTY_BIT]          = fifo_empty;
        status_w[ST_CNT_MSB:ST_CNT_LSB] = 4'(fifo_count);
        status_w[ST_OVF_BIT]            = fifo_ovf;
    end

    always_comb begin
        rdata = '0;
        case (region)
            RGN_RAM:    rdata = ram_q[addr[AW+1:2]];
            RGN_CYCLE:  rdata = cycle_q;
            RGN_STATUS: rdata = status_w;
            default:    rdata = '0;   // TXDATA and unmapped read as zero
        endcase
    end

    // Combinational read path: the core samples data in the same cycle.
    assign data = (rst_n && rd_en) ? rdata : 'z;

endmodule

// File: tb/tb_furv_dmem.sv
module tb_furv_dmem;

    localparam int RAM_WORDS  = 256;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] A_CYC = 32'h8000_0000;
    localparam logic [31:0] A_TX  = 32'h8000_0004;
    localparam logic [31:0] A_ST  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h10;
    logic        mem = 1'b0, mem_read = 1'b0, tx_ready = 1'b0;
    logic        drv = 1'b0;
    logic [31:0] drv_val = '0;
    logic        cmp_en = 1'b0;
    wire  [31:0] data;
    wire  [7:0]  tx_data;
    wire         tx_valid, bus_err;

    assign data = drv ? drv_val : 'z;
    always #5 clk = ~clk;

    furv_dmem #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .addr    (addr),
        .mem     (mem),
        .mem_read(mem_read),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_err (bus_err)
    );

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // bus must be released: Z in a 4-state simulator, 0 in a 2-state one
    task automatic chk_rel(input string name, input logic [31:0] act);
        checks++;
        if (!($isunknown(act) || act == 32'd0)) begin
            errs++;
            $display("FAIL %s: got %h want released bus", name, act);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned     mq[$];
    bit               m_ovf, m_berr;
    int unsigned      m_cycle;
    logic [31:0]      m_ram [int];
    int               m_r;
    bit               m_pop, m_push, m_full, m_clr;

    // 0 RAM, 1 CYCLE, 2 TXDATA, 3 STATUS, 4 unmapped
    function automatic int rgn(input logic [31:0] a);
        if (a < 32'(4 * RAM_WORDS))          return 0;
        if ((a & ~32'h3) == 32'h8000_0000)   return 1;
        if ((a & ~32'h3) == 32'h8000_0004)   return 2;
        if ((a & ~32'h3) == 32'h8000_0008)   return 3;
        return 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        case (rgn(a))
            0: return m_ram.exists(idx) ? m_ram[idx] : 32'd0;
            1: return m_cycle;
            3: return {25'd0, m_ovf, 4'(mq.size()), mq.size() == 0, mq.size() == FIFO_DEPTH};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_berr  = 1'b0;
            m_cycle = 0;
        end else begin
            m_r    = rgn(addr);
            m_pop  = tx_ready && mq.size() > 0;
            m_push = mem && !mem_read && m_r == 2;
            m_clr  = mem && mem_read && m_r == 3;
            m_full = mq.size() == FIFO_DEPTH;
            if (m_clr) m_ovf = 1'b0;
            if (m_push && m_full && !m_pop) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push && !(m_full && !m_pop)) mq.push_back(drv_val[7:0]);
            if (mem && !mem_read && m_r == 0) m_ram[int'(addr >> 2)] = drv_val;
            m_berr  = mem && m_r == 4;
            m_cycle = m_cycle + 1;
        end
    end

    // one compare process, every cycle once out of the initial reset
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, mq[0]});
            chk("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
            if (mem && mem_read) chk("rdata", data, m_read(addr));
            else if (drv)        chk("bus_wr", data, drv_val);
            else                 chk_rel("bus_idle", data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op_wr(input logic [31:0] a, input logic [31:0] v);
        mem = 1'b1; mem_read = 1'b0; addr = a; drv = 1'b1; drv_val = v;
    endtask
    task automatic op_rd(input logic [31:0] a);
        mem = 1'b1; mem_read = 1'b1; addr = a; drv = 1'b0;
    endtask
    task automatic op_idle();
        mem = 1'b0; mem_read = 1'b0; addr = 32'h10; drv = 1'b0;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        // reset state, with a read request active: bus stays released
        repeat (2) @(posedge clk);
        #1 op_rd(A_CYC);
        mid();
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk_rel("rst_data", data);
        #1 rst_n = 1'b1;
        #1 chk("cycle_at_release", data, 32'd0);
        nxt();
        cmp_en = 1'b1;
        mid();
        chk("cycle_first_edge", data, 32'd1);
        nxt();

        // RAM
        op_wr(32'h10, 32'hDEAD_BEEF); mid(); chk("ram_wr_bus", data, 32'hDEAD_BEEF); nxt();
        op_rd(32'h10); mid(); chk("ram_rd_10", data, 32'hDEAD_BEEF); nxt();
        op_rd(32'h13); mid(); chk("ram_rd_13", data, 32'hDEAD_BEEF); nxt();
        op_wr(32'h20, 32'hCAFE_F00D); nxt();
        op_wr(32'h20, 32'h0); mid(); chk("ram_overwrite_bus", data, 32'h0); nxt();
        op_rd(32'h20); mid(); chk("ram_rd_20", data, 32'h0); nxt();
        op_wr(32'h3FC, 32'h1234_5678); nxt();
        op_rd(32'h3FF); mid(); chk("ram_last_word", data, 32'h1234_5678); nxt();
        op_rd(32'h400); mid(); chk("ram_end_unmapped", data, 32'h0); nxt();
        op_idle(); mid(); chk("ram_end_berr", {31'd0, bus_err}, 32'd1); nxt();
        op_rd(A_CYC); nxt();
        op_rd(A_CYC); nxt();

        // FIFO ordering
        tx_ready = 1'b0;
        op_wr(A_TX, 32'h41); nxt();
        op_wr(A_TX, 32'h42); nxt();
        op_wr(A_TX, 32'h43); nxt();
        op_idle(); tx_ready = 1'b1;
        mid(); chk("fifo_b0", {24'd0, tx_data}, 32'h41); nxt();
        mid(); chk("fifo_b1", {24'd0, tx_data}, 32'h42); nxt();
        mid(); chk("fifo_b2", {24'd0, tx_data}, 32'h43); nxt();
        op_rd(A_ST); mid();
        chk("fifo_drained", {31'd0, tx_valid}, 32'd0);
        chk("fifo_status_empty", data, 32'h2);
        nxt();

        // overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin op_wr(A_TX, 32'h51 + i); nxt(); end
        op_rd(A_ST); mid(); chk("ovf_status", data, 32'h51); nxt();
        op_rd(A_ST); mid(); chk("ovf_status_cleared", data, 32'h11); nxt();
        op_idle(); tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("ovf_drain", {24'd0, tx_data}, 32'h51 + i); nxt();
        end
        mid(); chk("ovf_fifth_dropped", {31'd0, tx_valid}, 32'd0);
        nxt();

        // push and pop at the same edge while full
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin op_wr(A_TX, 32'h61 + i); nxt(); end
        tx_ready = 1'b1;
        op_wr(A_TX, 32'h65); nxt();
        op_wr(A_TX, 32'h66); nxt();
        tx_ready = 1'b0;
        op_rd(A_ST); mid();
        chk("pp_status", data, 32'h11);
        chk("pp_head", {24'd0, tx_data}, 32'h63);
        nxt();
        op_idle(); tx_ready = 1'b1;
        repeat (4) nxt();
        mid(); chk("pp_drained", {31'd0, tx_valid}, 32'd0);
        nxt();
        tx_ready = 1'b0;

        // unmapped region
        op_wr(32'h0, 32'h1111_2222); nxt();
        op_rd(32'h4000_0000); mid();
        chk("unm_rdata", data, 32'h0);
        chk("unm_berr_same", {31'd0, bus_err}, 32'd0);
        nxt();
        op_idle(); mid(); chk("unm_berr_pulse", {31'd0, bus_err}, 32'd1); nxt();
        mid(); chk("unm_berr_gone", {31'd0, bus_err}, 32'd0); nxt();
        op_wr(32'h4000_0000, 32'h5555_AAAA); nxt();
        op_idle(); mid(); chk("unm_wr_berr", {31'd0, bus_err}, 32'd1); nxt();
        op_rd(32'h0); mid(); chk("unm_wr_noeffect", data, 32'h1111_2222); nxt();
        op_rd(A_ST); mid(); chk("unm_wr_status", data, 32'h2); nxt();

        // reset mid-stream with three bytes queued
        for (int i = 0; i < 3; i++) begin op_wr(A_TX, 32'h71 + i); nxt(); end
        op_rd(A_CYC);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk_rel("rst_mid_data", data);
        mid();
        chk("rst_mid_berr", {31'd0, bus_err}, 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("rst_mid_cycle0", data, 32'd0);
        nxt();
        mid(); chk("rst_mid_cycle1", data, 32'd1); nxt();
        op_rd(32'h10); mid();
        chk("rst_ram_kept", data, 32'hDEAD_BEEF);
        chk("rst_fifo_empty", {31'd0, tx_valid}, 32'd0);
        nxt();
        op_idle(); nxt();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: stimulus did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule
